// File: rtl/spi_slave_peripheral_if.sv
// SPI pins plus the word-addressed register bus of the SPI slave peripheral.
// The slave modport is the peripheral's view; master is the host/bench view.
interface spi_slave_peripheral_if;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_wr_en;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, mem_addr, mem_wr_en, mem_wr_data,
    output spi_miso, spi_miso_oe, mem_rd_data
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, mem_addr, mem_wr_en, mem_wr_data,
    input  spi_miso, spi_miso_oe, mem_rd_data
  );
endinterface

// File: rtl/spi_slave_peripheral.sv
// SPI slave with oversampled SCLK, TX holding register, 4-deep RX FIFO and a
// small register map (CONTROL, TX_DATA, RX_DATA, STATUS, READ_AND_STATUS).
module spi_slave_peripheral #(
  parameter bit         CPOL    = 1'b0,
  parameter bit         CPHA    = 1'b0,
  parameter logic [7:0] TX_IDLE = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_slave_peripheral_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sclk_s, cs_s, mosi_s;
  logic        sclk_d, cs_d;
  logic        lead, trail, sample_edge, shift_edge, sample_ok, shift_ok;
  logic        load_tx, cs_rise_sel;
  logic [7:0]  tx_sr, rx_sr, rx_byte, tx_hold;
  logic        tx_valid, miso_q, push_pend;
  logic [2:0]  bit_cnt;
  logic [7:0]  fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        rx_overrun, tx_underrun;
  logic        wr_ctrl, wr_tx, pop_req, soft_rst, clr_flags, pop_ok, push_ok;
  logic [7:0]  head;
  logic        busy, rx_ne;
  logic        unused_bus;

  assign unused_bus = ^{bus.mem_wr_en[3:1], bus.mem_wr_data[31:8]};

  // 2-FF synchronizers plus one history stage for SCLK/CS edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_s <= {2{CPOL}};
      sclk_d <= CPOL;
      cs_s   <= 2'b11;
      cs_d   <= 1'b1;
      mosi_s <= 2'b00;
    end else begin
      sclk_s <= {sclk_s[0], bus.spi_sclk};
      sclk_d <= sclk_s[1];
      cs_s   <= {cs_s[0], bus.spi_cs_n};
      cs_d   <= cs_s[1];
      mosi_s <= {mosi_s[0], bus.spi_mosi};
    end
  end

  assign lead        = (sclk_s[1] != sclk_d) && (sclk_d == CPOL);
  assign trail       = (sclk_s[1] != sclk_d) && (sclk_s[1] == CPOL);
  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead : trail;
  assign sample_ok   = (state_q == SHIFT) && !cs_s[1] && sample_edge;
  // In mode CPHA=0 the byte-boundary reload already presents the next MSB,
  // so the trailing edge right after the 8th sample must not shift it away.
  assign shift_ok    = (state_q == SHIFT) && !cs_s[1] && shift_edge &&
                       (CPHA || (bit_cnt != 3'd0));
  assign cs_rise_sel = (state_q == SHIFT) && cs_s[1];

  assign wr_ctrl   = (bus.mem_addr == 8'h00) && bus.mem_wr_en[0];
  assign wr_tx     = (bus.mem_addr == 8'h01) && bus.mem_wr_en[0];
  assign pop_req   = wr_ctrl && bus.mem_wr_data[0];
  assign soft_rst  = wr_ctrl && bus.mem_wr_data[1];
  assign clr_flags = wr_ctrl && bus.mem_wr_data[2];
  assign pop_ok    = pop_req && (count != 3'd0);
  assign push_ok   = push_pend && ((count != 3'd4) || pop_ok);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load_tx = 1'b0;
    case (state_q)
      IDLE:    if (cs_d && !cs_s[1]) state_d = LOAD;
      LOAD:    begin state_d = SHIFT; load_tx = 1'b1; end
      SHIFT: begin
        if (cs_s[1])                          state_d = IDLE;
        else if (sample_edge && bit_cnt == 3'd7) load_tx = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (soft_rst) begin
      state_d = IDLE;
      load_tx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || soft_rst) begin
      tx_sr       <= 8'h00;
      rx_sr       <= 8'h00;
      rx_byte     <= 8'h00;
      bit_cnt     <= 3'd0;
      miso_q      <= 1'b0;
      push_pend   <= 1'b0;
      tx_hold     <= 8'h00;
      tx_valid    <= 1'b0;
      wr_ptr      <= 2'd0;
      rd_ptr      <= 2'd0;
      count       <= 3'd0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      if (cs_rise_sel) begin
        bit_cnt <= 3'd0;
        rx_sr   <= 8'h00;
      end else if (sample_ok) begin
        rx_sr   <= {rx_sr[6:0], mosi_s[1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      push_pend <= sample_ok && (bit_cnt == 3'd7);
      if (sample_ok && bit_cnt == 3'd7) rx_byte <= {rx_sr[6:0], mosi_s[1]};

      if (load_tx)       tx_sr <= tx_valid ? tx_hold : TX_IDLE;
      else if (shift_ok) tx_sr <= {tx_sr[6:0], 1'b0};
      if (state_q == LOAD) miso_q <= 1'b0;
      else if (shift_ok)   miso_q <= tx_sr[7];

      if (wr_tx) begin
        tx_hold  <= bus.mem_wr_data[7:0];
        tx_valid <= 1'b1;
      end else if (load_tx) begin
        tx_valid <= 1'b0;
      end

      if (clr_flags)            tx_underrun <= 1'b0;
      if (load_tx && !tx_valid) tx_underrun <= 1'b1;
      if (clr_flags)            rx_overrun  <= 1'b0;
      if (push_pend && !push_ok) rx_overrun <= 1'b1;

      if (push_ok) begin
        fifo_mem[wr_ptr] <= rx_byte;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 2'd1;
      if (push_ok && !pop_ok)      count <= count + 3'd1;
      else if (pop_ok && !push_ok) count <= count - 3'd1;
    end
  end

  assign busy  = (state_q != IDLE);
  assign rx_ne = (count != 3'd0);
  assign head  = rx_ne ? fifo_mem[rd_ptr] : 8'h00;

  assign bus.spi_miso_oe = busy;
  assign bus.spi_miso    = busy & (CPHA ? miso_q : tx_sr[7]);

  always_comb begin
    bus.mem_rd_data = 32'h0;
    if (rst) begin
      case (bus.mem_addr)
        8'h02:   bus.mem_rd_data = {24'h0, head};
        8'h03:   bus.mem_rd_data = {21'h0, count, 3'b000, tx_underrun, rx_overrun,
                                    busy, !tx_valid, rx_ne};
        8'h04:   bus.mem_rd_data = {22'h0, busy, rx_ne, head};
        default: bus.mem_rd_data = 32'h0;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave_peripheral.sv
// Bench for spi_slave_peripheral: a mode-0 and a mode-3 instance driven by a
// bit-banged SPI master and checked against a queue-based transaction model.
module tb_spi_slave_peripheral;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mode3 = 1'b0;
  logic        sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic [7:0]  addr = 8'h0;
  logic [3:0]  wr_en = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rd_w;
  logic        miso_w, oe_w;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  spi_slave_peripheral_if if0 ();
  spi_slave_peripheral_if if3 ();

  assign if0.spi_sclk    = mode3 ? 1'b0 : sclk;
  assign if0.spi_cs_n    = mode3 ? 1'b1 : cs_n;
  assign if0.spi_mosi    = mosi;
  assign if0.mem_addr    = addr;
  assign if0.mem_wr_en   = mode3 ? 4'h0 : wr_en;
  assign if0.mem_wr_data = wdata;
  assign if3.spi_sclk    = mode3 ? sclk : 1'b1;
  assign if3.spi_cs_n    = mode3 ? cs_n : 1'b1;
  assign if3.spi_mosi    = mosi;
  assign if3.mem_addr    = addr;
  assign if3.mem_wr_en   = mode3 ? wr_en : 4'h0;
  assign if3.mem_wr_data = wdata;
  assign rd_w   = mode3 ? if3.mem_rd_data : if0.mem_rd_data;
  assign miso_w = mode3 ? if3.spi_miso : if0.spi_miso;
  assign oe_w   = mode3 ? if3.spi_miso_oe : if0.spi_miso_oe;

  spi_slave_peripheral #(.CPOL(1'b0), .CPHA(1'b0), .TX_IDLE(8'hFF)) u_m0 (
    .clk(clk), .rst(rst), .bus(if0));
  spi_slave_peripheral #(.CPOL(1'b1), .CPHA(1'b1), .TX_IDLE(8'hFF)) u_m3 (
    .clk(clk), .rst(rst), .bus(if3));

  // Transaction-level model of the selected instance.
  logic [7:0] m_fifo[$];
  logic [7:0] m_tx;
  logic       m_tx_v, m_over, m_under;
  logic [7:0] mo_arr [8];
  logic [7:0] mi_arr [8];
  logic [7:0] exp_mi [9];

  typedef struct {
    logic        wr;
    logic [7:0]  a;
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] exp;
    string       nm;
  } vec_t;
  vec_t vecs [12];

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    addr = a; wr_en = be; wdata = d;
    @(negedge clk);
    wr_en = 4'h0; wdata = 32'h0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; wr_en = 4'h0;
    #1 d = rd_w;
  endtask

  function automatic logic [31:0] exp_status();
    return {21'h0, 3'(m_fifo.size()), 3'b000, m_under, m_over, 1'b0, !m_tx_v,
            m_fifo.size() != 0};
  endfunction

  function automatic logic [7:0] exp_head();
    return (m_fifo.size() != 0) ? m_fifo[0] : 8'h00;
  endfunction

  function automatic void model_reset();
    m_fifo.delete();
    m_tx_v = 1'b0; m_tx = 8'h00; m_over = 1'b0; m_under = 1'b0;
  endfunction

  // A frame with n full bytes performs n+1 TX loads: one at select, one per byte end.
  function automatic void model_frame(input int nbits);
    int nfull = nbits / 8;
    for (int k = 0; k <= nfull; k++) begin
      if (m_tx_v) begin exp_mi[k] = m_tx; m_tx_v = 1'b0; end
      else begin exp_mi[k] = 8'hFF; m_under = 1'b1; end
    end
    for (int k = 0; k < nfull; k++) begin
      if (m_fifo.size() < 4) m_fifo.push_back(mo_arr[k]);
      else m_over = 1'b1;
    end
  endfunction

  task automatic spi_bit(input logic mo, output logic mi);
    if (!mode3) begin
      mosi = mo; clk_n(4); mi = miso_w; sclk = 1'b1; clk_n(4); sclk = 1'b0;
    end else begin
      sclk = 1'b0; mosi = mo; clk_n(4); mi = miso_w; sclk = 1'b1; clk_n(4);
    end
  endtask

  task automatic frame(input int nbits);
    logic m;
    cs_n = 1'b0; clk_n(8);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(mo_arr[i/8][7-(i%8)], m);
      mi_arr[i/8][7-(i%8)] = m;
    end
    clk_n(4); cs_n = 1'b1; clk_n(8);
  endtask

  task automatic run_frame(input string nm, input int nbits);
    logic [31:0] d;
    model_frame(nbits);
    frame(nbits);
    for (int k = 0; k < nbits / 8; k++) chk({nm, "_miso"}, {24'h0, mi_arr[k]}, {24'h0, exp_mi[k]});
    rd(8'h03, d); chk({nm, "_status"}, d, exp_status());
    rd(8'h02, d); chk({nm, "_rxdata"}, d, {24'h0, exp_head()});
  endtask

  task automatic pop_chk(input string nm);
    logic [31:0] d;
    wr(8'h00, 4'h1, 32'h1);
    if (m_fifo.size() != 0) void'(m_fifo.pop_front());
    rd(8'h04, d);
    chk(nm, d, {22'h0, 1'b0, m_fifo.size() != 0, exp_head()});
  endtask

  task automatic tx_write(input logic [7:0] v);
    wr(8'h01, 4'h1, {24'h0, v});
    m_tx = v; m_tx_v = 1'b1;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        m;
    int          nb, np;
    model_reset();

    // Reset state
    clk_n(4);
    rd(8'h03, d);  chk("rst_status_zero", d, 32'h0);
    chk("rst_oe", {31'h0, oe_w}, 32'h0);
    chk("rst_miso", {31'h0, miso_w}, 32'h0);
    rst = 1'b1;
    clk_n(2);
    rd(8'h03, d);  chk("post_rst_status", d, exp_status());

    // Register-level table
    vecs[0]  = '{1'b0, 8'h00, 4'h0, 32'h0,   32'h0, "ctrl_reads0"};
    vecs[1]  = '{1'b1, 8'h01, 4'h1, 32'h5A,  32'h0, "tx_wr1"};
    vecs[2]  = '{1'b0, 8'h03, 4'h0, 32'h0,   32'h0, "tx_not_free"};
    vecs[3]  = '{1'b1, 8'h01, 4'h1, 32'hA5,  32'h0, "tx_overwrite"};
    vecs[4]  = '{1'b1, 8'h00, 4'h2, 32'h2,   32'h0, "ctrl_be1"};
    vecs[5]  = '{1'b0, 8'h03, 4'h0, 32'h0,   32'h0, "be_ignored"};
    vecs[6]  = '{1'b1, 8'h06, 4'hF, 32'h1,   32'h0, "unmapped_wr"};
    vecs[7]  = '{1'b0, 8'h05, 4'h0, 32'h0,   32'h0, "unmapped_rd"};
    vecs[8]  = '{1'b1, 8'h00, 4'h1, 32'h1,   32'h0, "pop_empty"};
    vecs[9]  = '{1'b0, 8'h03, 4'h0, 32'h0,   32'h0, "pop_empty_status"};
    vecs[10] = '{1'b0, 8'h04, 4'h0, 32'h0,   32'h0, "ras_empty"};
    vecs[11] = '{1'b0, 8'h02, 4'h0, 32'h0,   32'h0, "rx_empty"};
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) wr(vecs[i].a, vecs[i].be, vecs[i].d);
      else begin rd(vecs[i].a, d); chk(vecs[i].nm, d, vecs[i].exp); end
    end
    m_tx = 8'hA5; m_tx_v = 1'b1;

    // Mode 0 exchange A5 / 3C
    mo_arr[0] = 8'h3C;
    run_frame("m0_basic", 8);
    pop_chk("m0_basic_pop");

    // Overrun with 5 bytes, then drain in order
    wr(8'h00, 4'h1, 32'h4); m_over = 1'b0; m_under = 1'b0;
    for (int k = 0; k < 5; k++) mo_arr[k] = 8'(k + 1);
    run_frame("overrun", 40);
    for (int k = 0; k < 4; k++) pop_chk("drain");

    // Underrun and flag clear
    wr(8'h00, 4'h1, 32'h4); m_over = 1'b0; m_under = 1'b0;
    mo_arr[0] = 8'h99;
    run_frame("underrun", 8);
    wr(8'h00, 4'h1, 32'h4); m_over = 1'b0; m_under = 1'b0;
    rd(8'h03, d); chk("flag_clear", d, exp_status());
    pop_chk("underrun_pop");

    // Randomised frames against the model
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(1, 0) == 1) tx_write(8'($urandom));
      nb = $urandom_range(3, 1);
      np = ($urandom_range(3, 0) == 0) ? $urandom_range(7, 1) : 0;
      for (int k = 0; k < 4; k++) mo_arr[k] = 8'($urandom);
      run_frame("rand", nb * 8 + np);
      for (int p = $urandom_range(2, 0); p > 0; p--) pop_chk("rand_pop");
    end

    // Partial byte discarded, then a full byte
    wr(8'h00, 4'h1, 32'h2); model_reset();
    mo_arr[0] = 8'hF0;
    run_frame("partial", 5);
    mo_arr[0] = 8'h55;
    run_frame("after_partial", 8);
    rd(8'h03, d); chk("after_partial_cnt", {29'h0, d[10:8]}, 32'h1);

    // Soft reset landing on the same clk as the RX push
    wr(8'h00, 4'h1, 32'h2); model_reset();
    mo_arr[0] = 8'hC3;
    cs_n = 1'b0; clk_n(8);
    for (int i = 0; i < 7; i++) spi_bit(mo_arr[0][7-i], m);
    mosi = mo_arr[0][0]; clk_n(4); sclk = 1'b1; clk_n(3);
    addr = 8'h00; wdata = 32'h2; wr_en = 4'h1;
    @(negedge clk); wr_en = 4'h0; wdata = 32'h0;
    clk_n(4);
    rd(8'h03, d); chk("srst_race_cs_low", d, 32'h2);
    sclk = 1'b0; clk_n(4); cs_n = 1'b1; clk_n(8);
    rd(8'h03, d); chk("srst_race_status", d, 32'h2);
    rd(8'h02, d); chk("srst_race_rx", d, 32'h0);

    // Mode 3 exchanges on the second instance
    mode3 = 1'b1; sclk = 1'b1; model_reset();
    clk_n(8);
    tx_write(8'h81); mo_arr[0] = 8'h7E;
    run_frame("m3_a", 8);
    tx_write(8'h7E); mo_arr[0] = 8'h81;
    run_frame("m3_b", 8);
    pop_chk("m3_pop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_slave_peripheral.md
SPI_SLAVE_PERIPHERAL -- requirements
Module: spi_slave_peripheral

Interface
REQ-001 SHALL have parameter CPOL, default 0, SPI clock idle level.
REQ-002 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-003 SHALL have parameter TX_IDLE, default 8'hFF, byte shifted out when no TX byte is pending.
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port spi_sclk, input, 1, SPI clock from the master (asynchronous to clk).
REQ-007 SHALL have port spi_cs_n, input, 1, chip select from the master, active-low, asynchronous.
REQ-008 SHALL have port spi_mosi, input, 1, master-to-slave data, asynchronous.
REQ-009 SHALL have port spi_miso, output, 1, slave-to-master data, MSB first.
REQ-010 SHALL have port spi_miso_oe, output, 1, MISO pad output enable, high while selected.
REQ-011 SHALL have port mem_addr, input, 8, word address; byte offset = mem_addr*4.
REQ-012 SHALL have port mem_wr_en, input, 4, byte write enables, little-endian.
REQ-013 SHALL have port mem_wr_data, input, 32, write data.
REQ-014 SHALL have port mem_rd_data, output, 32, combinational read data.

Function
REQ-015 SHALL pass spi_sclk, spi_cs_n and spi_mosi through 2-FF synchronizers, then detect SCLK edges with one extra register stage; spi_sclk frequency SHALL be <= clk/8.
REQ-016 SHALL define the leading edge as the SCLK transition away from CPOL and the trailing edge as the transition back to CPOL.
REQ-017 SHALL use FSM states IDLE (CS high), LOAD (first cycle after synchronized CS fall), SHIFT (selected), with IDLE->LOAD on CS fall, LOAD->SHIFT unconditionally, SHIFT->IDLE on synchronized CS rise.
REQ-018 In LOAD, and after every 8th sample edge while still selected, SHALL load the TX shift register from the TX holding register if it is valid (then clear valid), else from TX_IDLE and set sticky TX_UNDERRUN.
REQ-019 CPHA=0: spi_miso SHALL present bit 7 from LOAD onward and shift on each trailing edge; CPHA=1: SHALL shift out on each leading edge, the first leading edge presenting bit 7.
REQ-020 SHALL sample the synchronized MOSI on each sample edge into an 8-bit RX shift register, MSB first, with a 3-bit counter wrapping 7->0.
REQ-021 On the 8th sample edge SHALL push the assembled byte into a 4-entry RX FIFO one clk later; if the FIFO is full, SHALL drop the byte and set sticky RX_OVERRUN.
REQ-022 On CS rise mid-byte SHALL discard the partial byte, reset the bit counter, leave the FIFO untouched, and keep an unsent TX holding byte valid.
REQ-023 spi_miso_oe SHALL be 1 in LOAD and SHIFT, else 0; spi_miso SHALL be 0 when spi_miso_oe is 0.
REQ-024 Register 0x00 CONTROL (write, byte 0): bit0 = RX pop, bit1 = soft reset, bit2 = clear sticky flags; reads return 0.
REQ-025 Register 0x04 TX_DATA (write, byte 0): SHALL load the TX holding register and set it valid; a write while already valid SHALL overwrite the byte.
REQ-026 Register 0x08 RX_DATA (read): {24'b0, FIFO head}; the value is 0 when the FIFO is empty; reads SHALL NOT pop.
REQ-027 Register 0x0C STATUS (read): bit0 rx_not_empty, bit1 tx_free (holding not valid), bit2 busy (not IDLE), bit3 RX_OVERRUN, bit4 TX_UNDERRUN, bits[10:8] FIFO count 0..4, other bits 0.
REQ-028 Register 0x10 READ_AND_STATUS (read): bits[7:0] FIFO head, bit8 rx_not_empty, bit9 busy, other bits 0; unmapped addresses SHALL read 0 and ignore writes.
REQ-029 A pop on an empty FIFO SHALL be ignored; a push and a pop in the same clk SHALL leave the count unchanged and keep data in order.
REQ-030 Soft reset SHALL clear the FIFO, flags, TX holding register, shift registers and counter, and return the FSM to IDLE until the next CS fall; it SHALL take precedence over a same-cycle push.

Reset
REQ-031 With rst low at a clk edge SHALL produce: FSM IDLE, FIFO empty, count 0, flags 0, TX holding invalid, spi_miso 0, spi_miso_oe 0, synchronizers loaded with CS high and SCLK = CPOL.
REQ-032 mem_rd_data SHALL read 0 while rst is low.

Verification
REQ-033 Mode 0: write TX_DATA 0xA5, master sends 0x3C with clk/8 SCLK -> MISO carries 0xA5, RX_DATA = 0x3C, STATUS bit0 = 1, tx_free = 1.
REQ-034 Mode 0: master sends 5 bytes 0x01..0x05 without pops -> count 4, head 0x01, RX_OVERRUN = 1; 4 pops drain 0x01..0x04 in order.
REQ-035 Master sends 1 byte with no TX written -> MISO = 0xFF, TX_UNDERRUN = 1; CONTROL bit2 write -> flag 0.
REQ-036 Mode 3 (CPOL=1, CPHA=1): exchange 0x81 and 0x7E -> both sides receive correctly.
REQ-037 CS deasserted after 5 bits, then a full byte 0x55 is sent -> FIFO holds only 0x55, count 1.
REQ-038 Soft reset written in the same clk as a byte push -> count 0, flags 0, busy 0.
